// File: rtl/dense_output_argmax_reader.sv
// dense_output_argmax_reader: starts the dense layer, then sweeps its logits for the signed argmax.
// Optional watchdog in WAIT_DONE enabled by CLASSIFIER_TIMEOUT_EN.
module dense_output_argmax_reader #(
  parameter int NUM_CLASSES    = 9,
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req,
  input  logic [4:0]        image_index,
  output logic              busy,
  output logic              layer_start,
  output logic [4:0]        layer_image_index,
  input  logic              layer_done,
  output logic [ADDR_W-1:0] layer_read_addr,
  input  logic [DATA_W-1:0] layer_read_data,
  output logic              result_valid,
  output logic [3:0]        result_class,
  output logic [DATA_W-1:0] result_score,
  output logic              timeout
);
  typedef enum logic [1:0] {IDLE, WAIT_DONE, READ} state_t;
  state_t state, state_n;
  logic done_q, done_rise, last, better, to_hit, accept;
  logic signed [DATA_W-1:0] max_v;
  logic [3:0] max_c;
  assign accept = (state == IDLE) && req;
  assign done_rise = layer_done & ~done_q;
  assign last = layer_read_addr == ADDR_W'(NUM_CLASSES - 1);
  assign better = (layer_read_addr == '0) || ($signed(layer_read_data) > max_v);
  assign busy = state != IDLE;
`ifdef CLASSIFIER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  logic timeout_r;
  assign to_hit = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  assign timeout = timeout_r;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cnt <= '0;
      timeout_r <= 1'b0;
    end else begin
      cnt <= accept ? '0 : (state == WAIT_DONE) ? cnt + 1'b1 : cnt;
      timeout_r <= (state == WAIT_DONE) && !done_rise && to_hit;
    end
`else
  assign to_hit = 1'b0;
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      state_n = req ? WAIT_DONE : IDLE;
      WAIT_DONE: state_n = done_rise ? READ : to_hit ? IDLE : WAIT_DONE;
      READ:      state_n = last ? IDLE : READ;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      done_q <= 1'b0;
      layer_start <= 1'b0;
      layer_image_index <= '0;
      layer_read_addr <= '0;
      result_valid <= 1'b0;
      result_class <= '0;
      result_score <= '0;
      max_v <= '0;
      max_c <= '0;
    end else begin
      state <= state_n;
      done_q <= layer_done;
      layer_start <= accept;
      result_valid <= 1'b0;
      if (accept) begin
        layer_image_index <= image_index;
        layer_read_addr <= '0;
      end
      if (state == WAIT_DONE && done_rise) layer_read_addr <= '0;
      if (state == WAIT_DONE && !done_rise && to_hit) begin
        result_valid <= 1'b1;
        result_class <= 4'hF;
        result_score <= '0;
      end
      if (state == READ) begin
        if (better) begin
          max_v <= $signed(layer_read_data);
          max_c <= 4'(layer_read_addr);
        end
        if (!last) layer_read_addr <= layer_read_addr + 1'b1;
        if (last) begin
          result_valid <= 1'b1;
          result_class <= better ? 4'(layer_read_addr) : max_c;
          result_score <= better ? layer_read_data : max_v;
        end
      end
    end
endmodule

// File: tb/tb_dense_output_argmax_reader.sv
// tb_dense_output_argmax_reader: directed + randomized checks against a plain argmax model.
module tb_dense_output_argmax_reader;
  logic clk = 0, resetn = 0, req = 0, layer_done = 0;
  logic [4:0] image_index = 0;
  logic busy, layer_start, result_valid, timeout;
  logic [4:0] layer_image_index;
  logic [3:0] layer_read_addr, result_class;
  logic [31:0] layer_read_data, result_score;
  int mem [9];
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;
  assign layer_read_data = (layer_read_addr < 9) ? mem[layer_read_addr] : 32'hDEAD_BEEF;

  dense_output_argmax_reader #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .resetn(resetn), .req(req), .image_index(image_index), .busy(busy),
    .layer_start(layer_start), .layer_image_index(layer_image_index), .layer_done(layer_done),
    .layer_read_addr(layer_read_addr), .layer_read_data(layer_read_data),
    .result_valid(result_valid), .result_class(result_class), .result_score(result_score),
    .timeout(timeout));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_argmax(output int c, output int s);
    c = 0;
    s = mem[0];
    for (int i = 1; i < 9; i++) if (mem[i] > s) begin s = mem[i]; c = i; end
  endfunction

  task automatic start_req(input logic [4:0] idx);
    req = 1; image_index = idx;
    @(posedge clk); #1;
    req = 0; image_index = 5'($urandom);
    chk("start_pulse", layer_start, 1);
    chk("busy_after_req", busy, 1);
    chk("image_latched", layer_image_index, idx);
    @(posedge clk); #1;
    chk("start_one_cycle", layer_start, 0);
    chk("image_held", layer_image_index, idx);
  endtask

  task automatic run_done();
    int n, c, s;
    ref_argmax(c, s);
    n = 0;
    layer_done = 1;
    do begin @(posedge clk); #1; n++; end while (!result_valid && n < 40);
    chk("valid_latency", n, 10);
    chk("busy_at_valid", busy, 0);
    chk("class", result_class, c);
    chk("score", result_score, s);
    chk("timeout_low", timeout, 0);
    @(posedge clk); #1;
    chk("valid_pulse", result_valid, 0);
    chk("class_hold", result_class, c);
    layer_done = 0;
  endtask

  task automatic random_mem(input bit narrow);
    for (int i = 0; i < 9; i++) mem[i] = narrow ? $urandom_range(0, 6) - 3 : int'($urandom);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 9; i++) mem[i] = 0;
    for (int i = 0; i < 5; i++) begin
      req = 1'($urandom); image_index = 5'($urandom); layer_done = 1'($urandom);
      @(posedge clk); #1;
      chk("rst_busy", busy, 0);
      chk("rst_start", layer_start, 0);
      chk("rst_valid", result_valid, 0);
      chk("rst_outs", {layer_image_index, layer_read_addr, result_class, timeout}, 0);
      chk("rst_score", result_score, 0);
    end
    req = 0; layer_done = 0;
    @(posedge clk); #1; resetn = 1;
    @(posedge clk); #1;

    mem = '{5, -3, 100, 7, 0, -50, 99, 1, 2};
    start_req(17);
    run_done();

    for (int i = 0; i < 9; i++) mem[i] = -12;
    start_req(5'($urandom));
    run_done();
    mem = '{-9, -8, -7, -6, -5, -4, -3, -1, -2};
    start_req(5'($urandom));
    run_done();

    layer_done = 1;
    repeat (3) @(posedge clk);
    #1;
    start_req(9);
    repeat (6) @(posedge clk);
    #1;
    chk("stale_busy", busy, 1);
    chk("stale_no_valid", result_valid, 0);
    layer_done = 0;
    @(posedge clk); #1;
    random_mem(0);
    run_done();

`ifdef CLASSIFIER_TIMEOUT_EN
    start_req(3);
    n = 1;
    do begin @(posedge clk); #1; n++; end while (!result_valid && n < 200);
    chk("to_cycle", n, 64);
    chk("to_flag", timeout, 1);
    chk("to_class", result_class, 15);
    chk("to_score", result_score, 0);
    @(posedge clk); #1;
    random_mem(0);
    start_req(4);
    run_done();
`endif

    random_mem(0);
    start_req(21);
    layer_done = 1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (layer_read_addr != 4 && n < 20);
    chk("reach_addr4", layer_read_addr, 4);
    resetn = 0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_outs", {layer_start, result_valid, layer_image_index, layer_read_addr, result_class}, 0);
    chk("mid_rst_score", result_score, 0);
    layer_done = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_no_valid", result_valid, 0);
    resetn = 1;
    @(posedge clk); #1;
    random_mem(0);
    start_req(30);
    run_done();

    for (int k = 0; k < 8; k++) begin
      random_mem(k[0]);
      start_req(5'($urandom));
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
      chk("wait_busy", busy, 1);
      run_done();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dense_output_argmax_reader.md
# dense_output_argmax_reader

Classification readout engine sitting at the output end of the 128-to-9 dense classifier layer. It issues the layer's one-cycle start, waits for the layer's done, then walks the layer's 9-entry output memory through its address/data read port. It reports the index and value of the largest signed 32-bit logit as the predicted class. It is the only consumer of the classifier's read port and the block that top-level control talks to for "classify image N".

## Interface

**Parameters**
- NUM_CLASSES, 9: number of logits read, addresses 0..NUM_CLASSES-1.
- DATA_W, 32: logit width, signed two's complement.
- ADDR_W, 4: read address width.
- TIMEOUT_CYCLES, 1048576: watchdog limit in WAIT_DONE; used only with CLASSIFIER_TIMEOUT_EN.

**Ports**
- clk, input, 1: single clock; all logic on rising edge.
- resetn, input, 1: asynchronous, active-low reset.
- req, input, 1: classification request; sampled only in IDLE.
- image_index, input, 5: image selector; latched when req is accepted.
- busy, output, 1: high whenever state is not IDLE.
- layer_start, output, 1: one-cycle start pulse to the dense layer.
- layer_image_index, output, 5: latched image_index; held stable while busy.
- layer_done, input, 1: dense layer done, level signal; only its rising edge is used.
- layer_read_addr, output, ADDR_W: registered read address into the layer output memory.
- layer_read_data, input, DATA_W: combinational read data for layer_read_addr, valid in the same cycle.
- result_valid, output, 1: one-cycle pulse when a result is presented.
- result_class, output, 4: argmax index; 4'hF on timeout.
- result_score, output, DATA_W: maximum logit; 0 on timeout.
- timeout, output, 1: qualifies result_valid as a watchdog abort. Tied 0 without the macro.

## Operation

- **Reset values:** all outputs 0; state IDLE; internal done_q 0; max register 0; counters 0.
- **Done detection:** done_q registers layer_done every cycle. done_rise = layer_done & ~done_q. A layer_done that is already high when the request is accepted is never treated as completion.
- **IDLE:** if req=1, latch image_index, set layer_start=1, clear layer_read_addr and the watchdog, go to WAIT_DONE. Otherwise hold.
- **WAIT_DONE:** layer_start returns to 0 after one cycle. On done_rise, go to READ with layer_read_addr=0.
- **READ:** each cycle, compare layer_read_data (signed) at the current address.
  - Address 0 loads max/class unconditionally.
  - Later addresses replace the stored value only if strictly greater, so ties keep the lowest index.
  - Increment the address.
  - When the address is NUM_CLASSES-1: register result_class/result_score from the final comparison, pulse result_valid, return to IDLE.
- **Comparison:** full DATA_W signed compare; no saturation and no truncation.
- **req while busy:** ignored, not queued.
- **req in the cycle result_valid is high:** state is IDLE, so the request is accepted.
- **result_class/result_score:** hold their value until the next result_valid.
- **Reset mid-operation:** returns to IDLE immediately. No result_valid, no layer_start.

## Timing

- req sampled at edge T. layer_start is high for the cycle following T. busy is high from after edge T.
- done_rise sampled at edge D. Entries 0..8 are sampled at edges D+1..D+9. result_valid is high for the cycle after edge D+9, and busy is low in that same cycle.
- Readout overhead after layer completion: 9 cycles of address sweep. Throughput: one result per layer run plus 10 cycles.
- layer_read_addr changes only at edges; the read data is assumed settled within the same cycle.

## Configuration

- **CLASSIFIER_TIMEOUT_EN defined:**
  - A counter runs in WAIT_DONE.
  - If TIMEOUT_CYCLES cycles elapse without done_rise: return to IDLE, pulse result_valid with timeout=1, result_class=4'hF, result_score=0.
  - The counter clears on every accepted req.
- **CLASSIFIER_TIMEOUT_EN not defined:** no counter, WAIT_DONE waits indefinitely, and timeout is constant 0.

## Test plan

- **Reset:** hold resetn=0 with random inputs → all outputs 0, busy=0, no layer_start.
- **Nominal:** logits {5,-3,100,7,0,-50,99,1,2}, req with image_index=17 → one layer_start, layer_image_index=17, result_class=2, result_score=100, result_valid exactly 10 cycles after the done_rise edge.
- **Ties and negatives:** all logits -12 → class 0, score -12. Then {-9,-8,-7,-6,-5,-4,-3,-1,-2} → class 7, score -1.
- **Stale done:** layer_done held high before req → no READ until layer_done falls and rises again; result taken from the fresh data.
- **Timeout (macro on, TIMEOUT_CYCLES=64):** no done after req → result_valid, timeout=1, result_class=15, result_score=0 at wait cycle 64. A following req gives a normal result.
- **Reset mid-READ:** assert resetn=0 at address 4 → outputs cleared, no result_valid. A subsequent req completes normally with correct argmax.
